ahb2wb_bridge: RTL and testbench

AHB-Lite slave to Wishbone classic master bridge for the ahb2spi subsystem. It accepts single AHB transfers from the AHB master and executes each one as a Wishbone classic cycle. The Wishbone side feeds the downstream Wishbone-to-SPI stage. Each AHB transfer is held with HREADY low until the Wishbone cycle is acknowledged or errors.

---
 rtl/ahb2wb_pkg.sv | 21 ++
 rtl/ahb2wb_if.sv | 40 ++++
 rtl/ahb2wb_watchdog.sv | 29 ++
 rtl/ahb2wb_bridge.sv | 191 +++++++++++++++++++
 tb/tb_ahb2wb_bridge.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb2wb_pkg.sv
// Shared types and AHB encodings for the AHB-Lite to Wishbone bridge.
package ahb2wb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WBCYC,
        ST_ERR1,
        ST_ERR2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

endpackage

// File: rtl/ahb2wb_if.sv
// AHB-Lite slave port and Wishbone classic master port of the bridge, bundled.
interface ahb2wb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
);
    logic                  hsel;
    logic [ADDR_W-1:0]     haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [DATA_W-1:0]     hwdata;
    logic                  hready;
    logic                  hresp;
    logic [DATA_W-1:0]     hrdata;

    logic [ADDR_W-1:0]     wb_adr_o;
    logic [DATA_W-1:0]     wb_dat_o;
    logic [DATA_W-1:0]     wb_dat_i;
    logic                  wb_we_o;
    logic [DATA_W/8-1:0]   wb_sel_o;
    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic                  wb_ack_i;
    logic                  wb_err_i;

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata,
        output hready, hresp, hrdata,
        output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata,
        input  hready, hresp, hrdata,
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );

endinterface

// File: rtl/ahb2wb_watchdog.sv
// Wishbone cycle watchdog: down-counter reloaded while idle, expires at terminal count.
module ahb2wb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_expired
);
    localparam int CNT_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W     = (CNT_W_RAW < 8) ? 8 : ((CNT_W_RAW > 16) ? 16 : CNT_W_RAW);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= LOAD;
        end else if (!i_en) begin
            r_cnt <= LOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Counter holds LOAD on the first enabled cycle, so zero is hit on cycle TIMEOUT_CYCLES.
    assign o_expired = i_en && (r_cnt == '0);

endmodule

// File: rtl/ahb2wb_bridge.sv
// AHB-Lite slave to Wishbone classic master bridge, one Wishbone cycle per AHB transfer.
// Define AHB2WB_TIMEOUT_EN to add a watchdog that errors out a stalled Wishbone cycle.
//
// state | meaning
// IDLE  | hready=1, accepts an address phase
// WDATA | write data phase, capture hwdata
// WBCYC | Wishbone cycle active, waiting for ack/err
// ERR1  | first ERROR cycle, hready=0 hresp=1
// ERR2  | second ERROR cycle, hready=1 hresp=1
module ahb2wb_bridge
    import ahb2wb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic     clk,
    input logic     rst,
    ahb2wb_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    if (!(DATA_W == 16 || DATA_W == 32) || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ahb2wb_bridge: DATA_W must be 16 or 32 and TIMEOUT_CYCLES positive");
    end

    state_t              r_state, w_state;
    logic                r_hready, w_hready;
    logic                r_hresp, w_hresp;
    logic [DATA_W-1:0]   r_hrdata, w_hrdata;
    logic [ADDR_W-1:0]   r_adr, w_adr;
    logic [DATA_W-1:0]   r_dat, w_dat;
    logic                r_we, w_we;
    logic [NB-1:0]       r_sel, w_sel;
    logic                r_cyc, w_cyc;

    logic                w_accept;
    logic                w_lane_ok;
    logic                w_timeout;
    logic [1:0]          w_off;
    logic [NB-1:0]       w_lane_base;
    logic [NB-1:0]       w_sel_dec;

    assign w_accept = bus.hsel && (bus.htrans == HTRANS_NONSEQ || bus.htrans == HTRANS_SEQ)
                      && r_hready && (r_state == ST_IDLE);

    assign w_off = 2'(bus.haddr[OFF_W-1:0]);

    // Sizes wider than the bus, or not naturally aligned, decode as illegal.
    always_comb begin
        w_lane_base = '0;
        w_lane_ok   = 1'b0;
        case (bus.hsize)
            HSIZE_BYTE: begin
                w_lane_base = NB'(1);
                w_lane_ok   = 1'b1;
            end
            HSIZE_HALF: begin
                w_lane_base = NB'(3);
                w_lane_ok   = ~w_off[0];
            end
            HSIZE_WORD: begin
                w_lane_base = NB'(15);
                w_lane_ok   = (NB >= 4) && (w_off == 2'b00);
            end
            default: begin
                w_lane_base = '0;
                w_lane_ok   = 1'b0;
            end
        endcase
    end

    assign w_sel_dec = w_lane_base << w_off;

`ifdef AHB2WB_TIMEOUT_EN
    ahb2wb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_en      (r_state == ST_WBCYC),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state  = r_state;
        w_hready = r_hready;
        w_hresp  = r_hresp;
        w_hrdata = r_hrdata;
        w_adr    = r_adr;
        w_dat    = r_dat;
        w_we     = r_we;
        w_sel    = r_sel;
        w_cyc    = r_cyc;
        case (r_state)
            ST_IDLE: begin
                w_hready = 1'b1;
                w_hresp  = 1'b0;
                if (w_accept) begin
                    w_adr    = bus.haddr;
                    w_we     = bus.hwrite;
                    w_sel    = w_sel_dec;
                    w_hready = 1'b0;
                    if (!w_lane_ok) begin
                        w_hresp = 1'b1;
                        w_state = ST_ERR1;
                    end else if (bus.hwrite) begin
                        w_state = ST_WDATA;
                    end else begin
                        w_cyc   = 1'b1;
                        w_state = ST_WBCYC;
                    end
                end
            end
            ST_WDATA: begin
                w_dat   = bus.hwdata;
                w_cyc   = 1'b1;
                w_state = ST_WBCYC;
            end
            ST_WBCYC: begin
                if (bus.wb_err_i || (!bus.wb_ack_i && w_timeout)) begin
                    w_cyc   = 1'b0;
                    w_hresp = 1'b1;
                    w_state = ST_ERR1;
                end else if (bus.wb_ack_i) begin
                    w_cyc    = 1'b0;
                    w_hready = 1'b1;
                    w_state  = ST_IDLE;
                    if (!r_we) begin
                        w_hrdata = bus.wb_dat_i;
                    end
                end
            end
            ST_ERR1: begin
                w_hready = 1'b1;
                w_hresp  = 1'b1;
                w_state  = ST_ERR2;
            end
            ST_ERR2: begin
                w_hready = 1'b1;
                w_hresp  = 1'b0;
                w_state  = ST_IDLE;
            end
            default: begin
                w_hready = 1'b1;
                w_hresp  = 1'b0;
                w_cyc    = 1'b0;
                w_state  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
            r_hrdata <= '0;
            r_adr    <= '0;
            r_dat    <= '0;
            r_we     <= 1'b0;
            r_sel    <= '0;
            r_cyc    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_hready <= w_hready;
            r_hresp  <= w_hresp;
            r_hrdata <= w_hrdata;
            r_adr    <= w_adr;
            r_dat    <= w_dat;
            r_we     <= w_we;
            r_sel    <= w_sel;
            r_cyc    <= w_cyc;
        end
    end

    assign bus.hready   = r_hready;
    assign bus.hresp    = r_hresp;
    assign bus.hrdata   = r_hrdata;
    assign bus.wb_adr_o = r_adr;
    assign bus.wb_dat_o = r_dat;
    assign bus.wb_we_o  = r_we;
    assign bus.wb_sel_o = r_sel;
    assign bus.wb_cyc_o = r_cyc;
    assign bus.wb_stb_o = r_cyc;

endmodule

// File: tb/tb_ahb2wb_bridge.sv
// Scoreboard bench for ahb2wb_bridge at DATA_W=16; timeout case built with AHB2WB_TIMEOUT_EN.
module tb_ahb2wb_bridge;
    import ahb2wb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 16;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ahb2wb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ahb2wb_bridge #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum int {R_OK, R_ERR, R_BOTH, R_NONE} resp_t;

    typedef struct {
        bit            we;
        logic [AW-1:0] adr;
        logic [1:0]    sel;
        logic [DW-1:0] wdat;
        logic [DW-1:0] rdat;
        int            resp_on;
        resp_t         kind;
        bit            err;
        int            waits;
        int            cycs;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            failures = 0;
    int            cycle = 0;
    int            first_cyc = 0;
    int            last_cyc = 0;
    logic [DW-1:0] model_hrdata = '0;

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic bus_idle();
        bus.hsel   = 1'b0;
        bus.htrans = HTRANS_IDLE;
        bus.hwrite = 1'b0;
        bus.hsize  = HSIZE_BYTE;
        bus.haddr  = '0;
    endtask

    // Drives one address phase in the current cycle and pushes the expected outcome.
    task automatic addr_phase(input bit we, input logic [AW-1:0] adr, input logic [2:0] size,
                              input logic [1:0] htr, input logic [DW-1:0] wdat,
                              input logic [DW-1:0] rdat, input int resp_on, input resp_t kind);
        exp_t e;
        bit   legal;
        legal     = (size == HSIZE_BYTE) || ((size == HSIZE_HALF) && (adr[0] == 1'b0));
        e.we      = we;
        e.adr     = adr;
        e.wdat    = wdat;
        e.rdat    = rdat;
        e.resp_on = resp_on;
        e.kind    = kind;
        e.sel     = (size == HSIZE_BYTE) ? (adr[0] ? 2'b10 : 2'b01) : 2'b11;
        if (!legal) begin
            e.err = 1'b1; e.cycs = 0; e.waits = 1;
        end else if (kind == R_NONE) begin
            e.err = 1'b1; e.cycs = TO; e.waits = TO + (we ? 2 : 1);
        end else if (kind == R_OK) begin
            e.err = 1'b0; e.cycs = resp_on; e.waits = resp_on + (we ? 1 : 0);
        end else begin
            e.err = 1'b1; e.cycs = resp_on; e.waits = resp_on + (we ? 2 : 1);
        end
        sb.push_back(e);
        checks++;
        if (bus.hready !== 1'b1) begin
            failures++;
            $display("FAIL addr_phase_hready adr=%h: got %b want 1", adr, bus.hready);
        end
        bus.hsel   = 1'b1;
        bus.htrans = htr;
        bus.hwrite = we;
        bus.haddr  = adr;
        bus.hsize  = size;
        tick();
        bus_idle();
        if (we) bus.hwdata = wdat;
    endtask

    // Plays the Wishbone slave until hready returns, then compares with the popped entry.
    task automatic data_phase();
        exp_t e;
        int   waits = 0;
        int   cycs = 0;
        bit   done = 1'b0;
        logic prev_hresp = 1'b0;
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_empty: got 0 entries want 1");
            return;
        end
        e = sb.pop_front();
        bus.wb_dat_i = e.rdat;
        for (int n = 0; n < 300; n++) begin
            if (bus.hready === 1'b1) begin
                done = 1'b1;
                break;
            end
            waits++;
            prev_hresp = bus.hresp;
            bus.wb_ack_i = 1'b0;
            bus.wb_err_i = 1'b0;
            if (bus.wb_cyc_o === 1'b1) begin
                cycs++;
                last_cyc = cycle;
                if (cycs == 1) begin
                    first_cyc = cycle;
                    checks++;
                    if ({bus.wb_adr_o, bus.wb_sel_o, bus.wb_we_o, bus.wb_stb_o} !== {e.adr, e.sel, e.we, 1'b1}) begin
                        failures++;
                        $display("FAIL wb_request: got adr=%h sel=%b we=%b stb=%b want adr=%h sel=%b we=%b stb=1",
                                 bus.wb_adr_o, bus.wb_sel_o, bus.wb_we_o, bus.wb_stb_o, e.adr, e.sel, e.we);
                    end
                    if (e.we) begin
                        checks++;
                        if (bus.wb_dat_o !== e.wdat) begin
                            failures++;
                            $display("FAIL wb_dat_o: got %h want %h", bus.wb_dat_o, e.wdat);
                        end
                    end
                end
                if (cycs == e.resp_on) begin
                    bus.wb_ack_i = (e.kind == R_OK) || (e.kind == R_BOTH);
                    bus.wb_err_i = (e.kind == R_ERR) || (e.kind == R_BOTH);
                end
            end
            tick();
        end
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        bus.wb_dat_i = 16'h5A5A;
        if (!e.we && !e.err) model_hrdata = e.rdat;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL completion_timeout adr=%h: got no hready want hready within 300 cycles", e.adr);
        end
        checks++;
        if (waits != e.waits) begin
            failures++;
            $display("FAIL wait_states adr=%h: got %0d want %0d", e.adr, waits, e.waits);
        end
        checks++;
        if (cycs != e.cycs) begin
            failures++;
            $display("FAIL wb_cyc_cycles adr=%h: got %0d want %0d", e.adr, cycs, e.cycs);
        end
        checks++;
        if (bus.hresp !== e.err) begin
            failures++;
            $display("FAIL final_hresp adr=%h: got %b want %b", e.adr, bus.hresp, e.err);
        end
        if (e.err) begin
            checks++;
            if (prev_hresp !== 1'b1) begin
                failures++;
                $display("FAIL err1_hresp adr=%h: got %b want 1", e.adr, prev_hresp);
            end
        end
        checks++;
        if (bus.hrdata !== model_hrdata) begin
            failures++;
            $display("FAIL hrdata adr=%h: got %h want %h", e.adr, bus.hrdata, model_hrdata);
        end
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if ({bus.hready, bus.hresp, bus.wb_cyc_o, bus.wb_stb_o} !== 4'b1000) begin
            failures++;
            $display("FAIL %s: got hready=%b hresp=%b cyc=%b stb=%b want 1 0 0 0",
                     name, bus.hready, bus.hresp, bus.wb_cyc_o, bus.wb_stb_o);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if ({bus.hready, bus.hresp, bus.hrdata, bus.wb_adr_o, bus.wb_dat_o, bus.wb_we_o,
             bus.wb_sel_o, bus.wb_cyc_o, bus.wb_stb_o} !== {1'b1, 1'b0, 16'h0, 32'h0, 16'h0, 1'b0, 2'b00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL %s: got hready=%b hresp=%b hrdata=%h adr=%h dat=%h we=%b sel=%b cyc=%b stb=%b want 1 0 0 0 0 0 0 0 0",
                     name, bus.hready, bus.hresp, bus.hrdata, bus.wb_adr_o, bus.wb_dat_o, bus.wb_we_o,
                     bus.wb_sel_o, bus.wb_cyc_o, bus.wb_stb_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_idle();
        bus.hwdata   = '0;
        bus.wb_dat_i = '0;
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        tick(); tick(); tick();
        check_reset_values("reset_values");
        rst = 1'b0;
        tick();
        check_reset_values("post_reset_idle");
        model_hrdata = '0;
    endtask

    task automatic test_halfword_read();
        addr_phase(1'b0, 32'h10, HSIZE_HALF, HTRANS_NONSEQ, '0, 16'hBEEF, 3, R_OK);
        data_phase();
        tick();
        addr_phase(1'b0, 32'h20, HSIZE_BYTE, HTRANS_NONSEQ, '0, 16'h1234, 1, R_OK);
        data_phase();
        tick();
    endtask

    task automatic test_byte_write();
        addr_phase(1'b1, 32'h21, HSIZE_BYTE, HTRANS_NONSEQ, 16'hA500, '0, 1, R_OK);
        data_phase();
        tick();
        addr_phase(1'b1, 32'h44, HSIZE_HALF, HTRANS_NONSEQ, 16'h3C3C, '0, 4, R_OK);
        data_phase();
        tick();
    endtask

    task automatic test_error();
        addr_phase(1'b0, 32'h50, HSIZE_HALF, HTRANS_NONSEQ, '0, 16'hDEAD, 1, R_ERR);
        data_phase();
        bus.hsel = 1'b1; bus.htrans = HTRANS_NONSEQ; bus.haddr = 32'h60; bus.hsize = HSIZE_HALF;
        tick();
        bus_idle();
        check_quiet("err2_transfer_ignored");
        tick();
        check_quiet("err2_transfer_no_cyc");
        addr_phase(1'b0, 32'h30, HSIZE_WORD, HTRANS_NONSEQ, '0, 16'h0, 1, R_OK);
        data_phase();
        tick();
        addr_phase(1'b1, 32'h31, HSIZE_HALF, HTRANS_NONSEQ, 16'h7777, '0, 1, R_OK);
        data_phase();
        tick();
        addr_phase(1'b1, 32'h52, HSIZE_HALF, HTRANS_NONSEQ, 16'h9999, '0, 2, R_ERR);
        data_phase();
        tick();
    endtask

    task automatic test_back_to_back();
        int rd_last;
        addr_phase(1'b0, 32'h70, HSIZE_HALF, HTRANS_NONSEQ, '0, 16'h1357, 2, R_OK);
        data_phase();
        rd_last = last_cyc;
        addr_phase(1'b1, 32'h72, HSIZE_HALF, HTRANS_SEQ, 16'hC0DE, '0, 1, R_OK);
        data_phase();
        checks++;
        if (first_cyc - rd_last != 3) begin
            failures++;
            $display("FAIL back_to_back_gap: got %0d want 3", first_cyc - rd_last);
        end
        tick();
    endtask

    task automatic test_idle_busy_stray();
        bus.hsel = 1'b1; bus.htrans = HTRANS_BUSY; bus.haddr = 32'h10; bus.hsize = HSIZE_HALF;
        tick();
        check_quiet("busy_no_cycle");
        bus.hsel = 1'b0; bus.htrans = HTRANS_NONSEQ;
        tick();
        check_quiet("unselected_no_cycle");
        bus.hsel = 1'b1; bus.htrans = HTRANS_IDLE;
        tick();
        bus_idle();
        check_quiet("idle_no_cycle");
        bus.wb_ack_i = 1'b1; bus.wb_err_i = 1'b1;
        tick();
        bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;
        check_quiet("stray_ack_err_ignored");
        tick();
        check_quiet("stray_ack_err_settled");
    endtask

    task automatic test_reset_and_priority();
        exp_t dropped;
        addr_phase(1'b0, 32'h80, HSIZE_HALF, HTRANS_NONSEQ, '0, 16'h2468, 2, R_BOTH);
        data_phase();
        tick();
        addr_phase(1'b0, 32'h90, HSIZE_HALF, HTRANS_NONSEQ, '0, 16'hFACE, 5, R_OK);
        checks++;
        if (bus.wb_cyc_o !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_cyc: got %b want 1", bus.wb_cyc_o);
        end
        #2 rst = 1'b1;
        #1;
        check_reset_values("mid_transfer_reset");
        model_hrdata = '0;
        dropped = sb.pop_front();
        tick();
        rst = 1'b0;
        tick();
        check_quiet("after_reset_release");
        addr_phase(1'b0, dropped.adr, HSIZE_HALF, HTRANS_NONSEQ, '0, 16'h0F0F, 1, R_OK);
        data_phase();
        tick();
    endtask

`ifdef AHB2WB_TIMEOUT_EN
    task automatic test_timeout();
        addr_phase(1'b0, 32'hA0, HSIZE_HALF, HTRANS_NONSEQ, '0, 16'h1111, 0, R_NONE);
        data_phase();
        tick();
        addr_phase(1'b1, 32'hA2, HSIZE_HALF, HTRANS_NONSEQ, 16'h2222, '0, 0, R_NONE);
        data_phase();
        tick();
    endtask
`else
    task automatic test_long_wait();
        addr_phase(1'b0, 32'hB0, HSIZE_HALF, HTRANS_NONSEQ, '0, 16'h4321, 20, R_OK);
        data_phase();
        tick();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish before 500000 time units");
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_halfword_read();
        test_byte_write();
        test_error();
        test_back_to_back();
        test_idle_busy_stray();
        test_reset_and_priority();
`ifdef AHB2WB_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
